// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and constants for the two-channel burst arbiter.
package mux_sel_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } arb_state_t;

    localparam int unsigned MAX_BURST_LEN = 255;

    // Burst counter width: max(1, clog2(burst_len)).
    function automatic int unsigned cnt_width(input int unsigned burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant/handshake bundle between the sources, the consumer and the arbiter.
interface mux_sel_arbiter_if;

    logic req_0;
    logic req_1;
    logic out_ready;
    logic sel;
    logic gnt_0;
    logic gnt_1;
    logic ack_0;
    logic ack_1;
    logic out_valid;
    logic last_beat;

    // Sources and consumer side.
    modport master (
        output req_0, req_1, out_ready,
        input  sel, gnt_0, gnt_1, ack_0, ack_1, out_valid, last_beat
    );

    // Arbiter side.
    modport slave (
        input  req_0, req_1, out_ready,
        output sel, gnt_0, gnt_1, ack_0, ack_1, out_valid, last_beat
    );

endinterface

// File: rtl/mux_sel_arbiter_burst_counter.sv
// Beat counter for the current grant; flags the final beat of a burst.
module mux_sel_arbiter_burst_counter #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic term_c
);

    logic [CNT_W-1:0] cnt_q;

    // Clear wins over increment so a release always restarts the burst at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign term_c = (cnt_q == CNT_W'(BURST_LEN - 1));

endmodule

// File: rtl/mux_sel_arbiter.sv
// Two-channel round-robin burst arbiter driving the select of a 2:1 data mux.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mux_sel_arbiter_if.slave      bus
);

    localparam int unsigned CNT_W = cnt_width(BURST_LEN);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       sel_q, sel_d;
    logic       cnt_inc, cnt_clr;
    logic       term_c;
    logic       own_c, req_own_c, req_oth_c;
    logic       out_valid_c, beat_c, release_c;

    assign own_c       = (state_q == ST_GNT1);
    assign req_own_c   = own_c ? bus.req_1 : bus.req_0;
    assign req_oth_c   = own_c ? bus.req_0 : bus.req_1;
    assign out_valid_c = ((state_q == ST_GNT0) & bus.req_0) | ((state_q == ST_GNT1) & bus.req_1);
    assign beat_c      = out_valid_c & bus.out_ready;
    assign release_c   = (beat_c & term_c) | ~req_own_c;

    mux_sel_arbiter_burst_counter #(
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) u_burst_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (cnt_inc),
        .clr     (cnt_clr),
        .term_c  (term_c)
    );

    // State, last-served pointer and mux select registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    // Grant selection: round-robin on ties, handover without bubbles on release.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (bus.req_0 && bus.req_1) begin
                    state_d = last_q ? ST_GNT0 : ST_GNT1;
                end else if (bus.req_0) begin
                    state_d = ST_GNT0;
                end else if (bus.req_1) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (release_c) begin
                    cnt_clr = 1'b1;
                    last_d  = own_c;
                    if (req_oth_c) begin
                        state_d = own_c ? ST_GNT0 : ST_GNT1;
                    end else if (req_own_c) begin
                        state_d = state_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_inc = beat_c;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
        if (state_d == ST_GNT0) begin
            sel_d = 1'b0;
        end else if (state_d == ST_GNT1) begin
            sel_d = 1'b1;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt_0     = (state_q == ST_GNT0);
    assign bus.gnt_1     = (state_q == ST_GNT1);
    assign bus.ack_0     = (state_q == ST_GNT0) & bus.out_ready;
    assign bus.ack_1     = (state_q == ST_GNT1) & bus.out_ready;
    assign bus.out_valid = out_valid_c;
    assign bus.last_beat = out_valid_c & term_c;

endmodule
